eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Transmit-side Ethernet frame sequencer for the MMIO Ethernet peripheral. It accepts a payload byte stream (destination MAC through the end of the payload) and emits a PHY-ready byte stream: a 7-byte preamble, SFD, payload, zero padding to the minimum length, the 4-byte FCS, and then the inter-frame gap. It controls the existing byte-wide CRC32 engine (`crc_clear`/`crc_en`/data in, `crc_data` back) and serialises the FCS from it. No CRC logic lives in this block.

## Interface
- `MIN_LEN`, 60: minimum byte count before the FCS (payload plus pad); 0 disables padding.
- `IFG_CYCLES`, 12: idle cycles in the IFG state after the last FCS byte.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  payload byte valid.
- `s_last`  in  1  last payload byte of the frame.
- `s_ready`  out  1  payload byte accepted when `s_valid && s_ready`.
- `tx_data`  out  8  registered byte to the PHY.
- `tx_en`  out  1  registered; high while a frame byte is on `tx_data`.
- `tx_er`  out  1  registered; error marker on the PHY byte.
- `crc_din`  out  8  byte fed to the CRC engine.
- `crc_en`  out  1  CRC engine update strobe.
- `crc_clear`  out  1  CRC engine reset to 0xFFFFFFFF.
- `crc_data`  in  32  current CRC engine register.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when the last FCS byte is registered.
- `err_underrun`  out  1  one-cycle pulse when an underrun is detected.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG. Reset puts the FSM in IDLE.
- IDLE: `crc_clear=1`. If `s_valid` is high, go to PRE. The byte is not consumed.
- PRE: 7 cycles, each emitting 0x55. Then go to SFD.
- SFD: 1 cycle, emitting 0xD5. Then go to DATA.
- DATA: `s_ready=1`.
  - Each accepted byte is emitted, with `crc_din=s_data` and `crc_en=1`.
  - The 11-bit length counter increments and saturates at 2047.
  - On an accepted `s_last`: go to PAD if the updated count is below `MIN_LEN`, otherwise go to FCS.
- DATA with `s_valid` low (underrun):
  - Emit 0x00 with `tx_er=1`, pulse `err_underrun`, and go to DROP.
  - Do not pulse `crc_en`.
- PAD: emit 0x00 with `crc_din=0x00` and `crc_en=1`, and count up. When the count reaches `MIN_LEN`, go to FCS.
- FCS: 4 cycles. Byte k (k=0..3) is `~bitrev8(crc_data[31-8k -: 8])`.
  - `crc_en=0`, so `crc_data` is stable.
  - `bitrev8` swaps bit i with bit 7-i.
  - The last byte pulses `frame_done` (aligned with its `tx_en` cycle) and moves to IFG.
- DROP: `s_ready=1`, `tx_en=0`. Discard bytes until `s_valid && s_last` is accepted, then go to IFG.
- IFG: count `IFG_CYCLES` cycles with `tx_en=0`, then go to IDLE. The length counter clears on IDLE entry.
- `s_ready` is 0 in every state except DATA and DROP. `crc_en` is 0 outside DATA and PAD.
- `crc_din`, `crc_en`, `crc_clear`, `s_ready` and `busy` are combinational from the state and inputs. `tx_*`, `frame_done` and `err_underrun` are registered.

## Timing
- Reset values:
  - `tx_data=0x00`, `tx_en=0`, `tx_er=0`, `frame_done=0`, `err_underrun=0`.
  - `s_ready=0`, `crc_en=0`, `crc_clear=1`, `busy=0`.
- Each state cycle produces its `tx_*` byte one cycle later.
- With `s_valid` first seen in IDLE at cycle T, the first 0x55 appears on `tx_en` at T+2.
- For an N-byte payload with no underrun:
  - `tx_en` is high for 8+max(N,MIN_LEN)+4 consecutive cycles.
  - DATA is contiguous only if `s_valid` stays high.
- The CRC engine sees the last DATA/PAD byte at the edge that enters FCS, so `crc_data` is final throughout FCS.
- Between back-to-back frames, the `tx_en`-low gap is at least `IFG_CYCLES+1` cycles.
- `s_last` on the first DATA byte is legal (N=1). There is no N=0 frame.
- Reset mid-frame: the next cycle shows IDLE, `tx_en=0` and `crc_clear=1`. No `frame_done` or `err_underrun` is produced.
- When the counter is saturated at 2047, the frame still completes normally; no FCS truncation.

## Test plan
- `MIN_LEN=0`, payload 31..39 ("123456789") with `s_valid` held high → `tx_en` is high for 21 cycles: 55×7, D5, 31..39, then 26 39 F4 CB; `frame_done` pulses on CB.
- `MIN_LEN=60`, 14-byte payload → 46 bytes of 0x00 after the payload, then 4 FCS bytes matching a software CRC32 of all 60 bytes; `tx_en` is high for 72 cycles.
- Underrun: `s_valid` drops after the 5th DATA byte → one byte 0x00 with `tx_en=1`, `tx_er=1`, `err_underrun` pulse; `s_ready` stays high until `s_last`; no FCS; no `frame_done`.
- Back-to-back: two 64-byte frames with `s_valid` held high → exactly 13 `tx_en`-low cycles between them; both FCS values are correct, confirming `crc_clear` in IDLE.
- Assert `rst` during the 3rd payload byte → next cycle `tx_en=0`, `busy=0`, `crc_clear=1`; a following frame transmits with a correct FCS.
- 2100-byte payload → counter saturates at 2047; FCS is correct; `tx_en` is high for 8+2100+4 cycles.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - payload byte stream into the Ethernet TX framer
//
// Carries the payload byte stream (destination MAC through end of payload).
//   s_data   payload byte
//   s_valid  s_data holds a byte
//   s_last   current byte ends the frame
//   s_ready  byte accepted on s_valid && s_ready
// master: payload source, slave: framer.
interface eth_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - transmit Ethernet frame sequencer (preamble/SFD/payload/pad/FCS/IFG)
//
// Turns one payload burst into one PHY frame: 7x 0x55, 0xD5, payload, zero pad
// up to MIN_LEN, 4 FCS bytes, then an inter-frame gap. The CRC itself lives in
// an external byte-wide engine; this block only clears/feeds it and serialises
// its register as the FCS.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   s (slave)          payload stream s_data/s_valid/s_last in, s_ready out
//   tx_data            registered PHY byte
//   tx_en              registered; high while a frame byte is on tx_data
//   tx_er              registered; error marker on the PHY byte
//   crc_din            byte fed to the CRC engine
//   crc_en             CRC engine update strobe
//   crc_clear          CRC engine reset to all ones
//   crc_data           CRC engine register (MSB-first form)
//   busy               FSM is not in IDLE
//   frame_done         pulse aligned with the last FCS byte on tx
//   err_underrun       pulse aligned with the tx_er byte of an underrun
module eth_tx_framer #(
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic           clk,
  input  logic           rst,
  eth_tx_framer_if.slave s,
  output logic [7:0]     tx_data,
  output logic           tx_en,
  output logic           tx_er,
  output logic [7:0]     crc_din,
  output logic           crc_en,
  output logic           crc_clear,
  input  logic [31:0]    crc_data,
  output logic           busy,
  output logic           frame_done,
  output logic           err_underrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4,
    FCS  = 3'd5,
    DROP = 3'd6,
    IFG  = 3'd7
  } state_t;

  state_t      state;
  state_t      state_next;

  // Phase counter for PRE, FCS and IFG; cleared whenever the state changes.
  logic [15:0] cnt;
  // Frame length (payload + pad) seen so far; saturates so long frames still finish.
  logic [10:0] len;
  logic [10:0] len_inc;

  logic        s_ready_c;
  logic        accept;

  // Next values of the registered PHY-side outputs.
  logic [7:0]  tx_data_d;
  logic        tx_en_d;
  logic        tx_er_d;
  logic        frame_done_d;
  logic        err_underrun_d;

  // FCS byte source selected from the engine register.
  logic [7:0]  fcs_src;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  assign s.s_ready = s_ready_c;
  assign accept    = s.s_valid && s_ready_c;
  assign len_inc   = (len == 11'd2047) ? len : len + 11'd1;

  always_comb begin
    fcs_src = crc_data[31:24];
    case (cnt[1:0])
      2'd0:    fcs_src = crc_data[31:24];
      2'd1:    fcs_src = crc_data[23:16];
      2'd2:    fcs_src = crc_data[15:8];
      default: fcs_src = crc_data[7:0];
    endcase
  end

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
      len   <= 11'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
      // len counts bytes that went through the CRC engine (payload + pad).
      if (state == IDLE) begin
        len <= 11'd0;
      end else if ((state == DATA && accept) || state == PAD) begin
        len <= len_inc;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // The waiting byte is left on the stream; DATA consumes it.
        if (s.s_valid) state_next = PRE;
      end
      PRE: begin
        if (cnt == 16'd6) state_next = SFD;
      end
      SFD: begin
        state_next = DATA;
      end
      DATA: begin
        if (!s.s_valid) begin
          state_next = DROP;
        end else if (s.s_last) begin
          state_next = (int'(len_inc) < MIN_LEN) ? PAD : FCS;
        end
      end
      PAD: begin
        if (int'(len_inc) >= MIN_LEN) state_next = FCS;
      end
      FCS: begin
        if (cnt == 16'd3) state_next = IFG;
      end
      DROP: begin
        if (s.s_valid && s.s_last) state_next = IFG;
      end
      IFG: begin
        if (int'(cnt) >= IFG_CYCLES - 1) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: combinational controls plus next values of the tx registers.
  always_comb begin
    s_ready_c      = 1'b0;
    crc_din        = 8'h00;
    crc_en         = 1'b0;
    crc_clear      = 1'b0;
    busy           = (state != IDLE);
    tx_data_d      = 8'h00;
    tx_en_d        = 1'b0;
    tx_er_d        = 1'b0;
    frame_done_d   = 1'b0;
    err_underrun_d = 1'b0;
    case (state)
      IDLE: begin
        crc_clear = 1'b1;
      end
      PRE: begin
        tx_data_d = 8'h55;
        tx_en_d   = 1'b1;
      end
      SFD: begin
        tx_data_d = 8'hD5;
        tx_en_d   = 1'b1;
      end
      DATA: begin
        s_ready_c = 1'b1;
        if (s.s_valid) begin
          tx_data_d = s.s_data;
          tx_en_d   = 1'b1;
          crc_din   = s.s_data;
          crc_en    = 1'b1;
        end else begin
          // Source ran dry mid-frame: poison the byte on the wire and abandon.
          tx_data_d      = 8'h00;
          tx_en_d        = 1'b1;
          tx_er_d        = 1'b1;
          err_underrun_d = 1'b1;
        end
      end
      PAD: begin
        tx_data_d = 8'h00;
        tx_en_d   = 1'b1;
        crc_din   = 8'h00;
        crc_en    = 1'b1;
      end
      FCS: begin
        // Engine holds the MSB-first register; the wire wants it reflected and inverted.
        tx_data_d    = ~bitrev8(fcs_src);
        tx_en_d      = 1'b1;
        frame_done_d = (cnt == 16'd3);
      end
      DROP: begin
        s_ready_c = 1'b1;
      end
      IFG: begin
      end
      default: begin
      end
    endcase
  end

  // Registered PHY-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data      <= 8'h00;
      tx_en        <= 1'b0;
      tx_er        <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      tx_data      <= tx_data_d;
      tx_en        <= tx_en_d;
      tx_er        <= tx_er_d;
      frame_done   <= frame_done_d;
      err_underrun <= err_underrun_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - self-checking bench for eth_tx_framer (MIN_LEN 0 and 60 instances)
module tb_eth_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       er;
    logic       done;
    logic       und;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       sel = 1'b0;
  logic [7:0] src_data  = 8'h00;
  logic       src_valid = 1'b0;
  logic       src_last  = 1'b0;

  eth_tx_framer_if if0();
  eth_tx_framer_if if1();
  assign if0.s_data  = src_data;
  assign if0.s_valid = src_valid && !sel;
  assign if0.s_last  = src_last;
  assign if1.s_data  = src_data;
  assign if1.s_valid = src_valid && sel;
  assign if1.s_last  = src_last;

  logic [7:0]  tx_data0, tx_data1, crc_din0, crc_din1;
  logic        tx_en0, tx_en1, tx_er0, tx_er1, crc_en0, crc_en1, crc_clear0, crc_clear1;
  logic        busy0, busy1, frame_done0, frame_done1, err_und0, err_und1;
  logic [31:0] crc_data0, crc_data1;
  logic [31:0] refl0 = 32'hFFFF_FFFF;
  logic [31:0] refl1 = 32'hFFFF_FFFF;

  eth_tx_framer #(.MIN_LEN(0), .IFG_CYCLES(12)) dut0 (
    .clk(clk), .rst(rst), .s(if0),
    .tx_data(tx_data0), .tx_en(tx_en0), .tx_er(tx_er0),
    .crc_din(crc_din0), .crc_en(crc_en0), .crc_clear(crc_clear0), .crc_data(crc_data0),
    .busy(busy0), .frame_done(frame_done0), .err_underrun(err_und0)
  );

  eth_tx_framer #(.MIN_LEN(60), .IFG_CYCLES(12)) dut1 (
    .clk(clk), .rst(rst), .s(if1),
    .tx_data(tx_data1), .tx_en(tx_en1), .tx_er(tx_er1),
    .crc_din(crc_din1), .crc_en(crc_en1), .crc_clear(crc_clear1), .crc_data(crc_data1),
    .busy(busy1), .frame_done(frame_done1), .err_underrun(err_und1)
  );

  // Reflected CRC32 byte update (poly 0xEDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // CRC engine models: byte-wide, register exposed in MSB-first form.
  always @(posedge clk) begin
    if (crc_clear0) refl0 <= 32'hFFFF_FFFF;
    else if (crc_en0) refl0 <= crc_upd(refl0, crc_din0);
    if (crc_clear1) refl1 <= 32'hFFFF_FFFF;
    else if (crc_en1) refl1 <= crc_upd(refl1, crc_din1);
  end
  assign crc_data0 = bitrev32(refl0);
  assign crc_data1 = bitrev32(refl1);

  logic [7:0] m_tx_data;
  logic       m_tx_en, m_tx_er, m_done, m_und, m_ready, m_busy, m_clear;
  assign m_tx_data = sel ? tx_data1    : tx_data0;
  assign m_tx_en   = sel ? tx_en1      : tx_en0;
  assign m_tx_er   = sel ? tx_er1      : tx_er0;
  assign m_done    = sel ? frame_done1 : frame_done0;
  assign m_und     = sel ? err_und1    : err_und0;
  assign m_ready   = sel ? if1.s_ready : if0.s_ready;
  assign m_busy    = sel ? busy1       : busy0;
  assign m_clear   = sel ? crc_clear1  : crc_clear0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  exp_t exp_q[$];
  int run = 0, gap = 0, last_run = 0, last_gap = 0, first_tx_cyc = 0, drv_cyc0 = 0;

  // Scoreboard: every tx_en byte is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (m_tx_en) begin
      if (run == 0) begin
        last_gap     = gap;
        first_tx_cyc = cyc;
      end
      run++;
      gap = 0;
      if (exp_q.size() == 0) begin
        check("unexpected_tx_byte", 32'(m_tx_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(m_tx_data), 32'(e.data));
        check("tx_er", 32'(m_tx_er), 32'(e.er));
        check("frame_done", 32'(m_done), 32'(e.done));
        check("err_underrun", 32'(m_und), 32'(e.und));
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      gap++;
      check("frame_done_idle", 32'(m_done), 32'd0);
      check("err_underrun_idle", 32'(m_und), 32'd0);
    end
  end

  task automatic push_b(input logic [7:0] d, input logic er, input logic done, input logic und);
    exp_t e;
    e.data = d; e.er = er; e.done = done; e.und = und;
    exp_q.push_back(e);
  endtask

  task automatic push_pre();
    for (int i = 0; i < 7; i++) push_b(8'h55, 1'b0, 1'b0, 1'b0);
    push_b(8'hD5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input bq_t pl, input int min_len);
    logic [31:0] c;
    int n;
    c = 32'hFFFF_FFFF;
    push_pre();
    foreach (pl[i]) begin
      push_b(pl[i], 1'b0, 1'b0, 1'b0);
      c = crc_upd(c, pl[i]);
    end
    n = pl.size();
    while (n < min_len) begin
      push_b(8'h00, 1'b0, 1'b0, 1'b0);
      c = crc_upd(c, 8'h00);
      n++;
    end
    c = ~c;
    push_b(c[7:0], 1'b0, 1'b0, 1'b0);
    push_b(c[15:8], 1'b0, 1'b0, 1'b0);
    push_b(c[23:16], 1'b0, 1'b0, 1'b0);
    push_b(c[31:24], 1'b0, 1'b1, 1'b0);
  endtask

  function automatic bq_t make_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // Presents bytes at negedges; leaves s_valid high on return.
  task automatic drive_bytes(input bq_t pl, input bit mark_last);
    int i = 0;
    int guard = 0;
    bit acc;
    bit first = 1'b1;
    while (i < pl.size()) begin
      @(negedge clk);
      src_data  = pl[i];
      src_valid = 1'b1;
      src_last  = mark_last && (i == pl.size() - 1);
      if (first) begin
        drv_cyc0 = cyc;
        first    = 1'b0;
      end
      #1;
      acc = m_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > pl.size() + 400) begin
        check("drive_timeout", 32'(i), 32'(pl.size()));
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
    while (m_busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_idle_timeout", 32'(m_busy), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, observed cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, q;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data0), 32'd0);
    check("rst_tx_en", 32'(tx_en0), 32'd0);
    check("rst_tx_er", 32'(tx_er0), 32'd0);
    check("rst_frame_done", 32'(frame_done0), 32'd0);
    check("rst_err_underrun", 32'(err_und0), 32'd0);
    check("rst_s_ready", 32'(if0.s_ready), 32'd0);
    check("rst_crc_en", 32'(crc_en0), 32'd0);
    check("rst_crc_clear", 32'(crc_clear0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_busy_b", 32'(busy1), 32'd0);
    check("rst_crc_clear_b", 32'(crc_clear1), 32'd1);
    rst = 1'b0;

    // MIN_LEN=0, "123456789": check value 0xCBF43926 sent LSB byte first.
    sel = 1'b0;
    wait_idle();
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    push_pre();
    foreach (p[i]) push_b(p[i], 1'b0, 1'b0, 1'b0);
    push_b(8'h26, 1'b0, 1'b0, 1'b0);
    push_b(8'h39, 1'b0, 1'b0, 1'b0);
    push_b(8'hF4, 1'b0, 1'b0, 1'b0);
    push_b(8'hCB, 1'b0, 1'b1, 1'b0);
    drive_bytes(p, 1'b1);
    wait_idle();
    check("check_frame_len", 32'(last_run), 32'd21);
    check("first_preamble_latency", 32'(first_tx_cyc - drv_cyc0), 32'd2);

    // MIN_LEN=0, single-byte frame.
    p = make_payload(1);
    push_frame(p, 0);
    drive_bytes(p, 1'b1);
    wait_idle();
    check("n1_frame_len", 32'(last_run), 32'd13);

    // Underrun after the 5th DATA byte: s_ready held until s_last, no FCS.
    p = make_payload(12);
    push_pre();
    for (int i = 0; i < 5; i++) push_b(p[i], 1'b0, 1'b0, 1'b0);
    push_b(8'h00, 1'b1, 1'b0, 1'b1);
    drive_bytes(p[0:4], 1'b0);
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("drop_s_ready", 32'(m_ready), 32'd1);
    check("drop_busy", 32'(m_busy), 32'd1);
    drive_bytes(p[5:$], 1'b1);
    wait_idle();
    check("underrun_frame_len", 32'(last_run), 32'd14);

    // MIN_LEN=60, 14-byte payload padded to 60.
    sel = 1'b1;
    wait_idle();
    p = make_payload(14);
    push_frame(p, 60);
    drive_bytes(p, 1'b1);
    wait_idle();
    check("pad_frame_len", 32'(last_run), 32'd72);
    check("pad_latency", 32'(first_tx_cyc - drv_cyc0), 32'd2);

    // Back-to-back 64-byte frames with s_valid held high.
    p = make_payload(64);
    q = make_payload(64);
    push_frame(p, 60);
    push_frame(q, 60);
    drive_bytes(p, 1'b1);
    drive_bytes(q, 1'b1);
    wait_idle();
    check("b2b_gap", 32'(last_gap), 32'd13);
    check("b2b_frame_len", 32'(last_run), 32'd76);

    // Reset during the 3rd payload byte, then a clean frame.
    p = make_payload(20);
    push_pre();
    push_b(p[0], 1'b0, 1'b0, 1'b0);
    push_b(p[1], 1'b0, 1'b0, 1'b0);
    drive_bytes(p[0:1], 1'b0);
    @(negedge clk);
    src_data = p[2];
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_en", 32'(m_tx_en), 32'd0);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_crc_clear", 32'(m_clear), 32'd1);
    check("midrst_exp_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    src_valid = 1'b0;
    src_last  = 1'b0;
    wait_idle();
    p = make_payload(61);
    push_frame(p, 60);
    drive_bytes(p, 1'b1);
    wait_idle();
    check("post_rst_frame_len", 32'(last_run), 32'd73);

    // Length counter saturation: 2100-byte payload.
    p = make_payload(2100);
    push_frame(p, 60);
    drive_bytes(p, 1'b1);
    wait_idle();
    check("long_frame_len", 32'(last_run), 32'd2112);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
